// File: rtl/sub_nibble.sv
// sub_nibble: masked 4-bit S-box substitution over a 32-bit word.
// The operands are latched on a start event. One nibble is processed per cycle, LSB nibble
// first. After 8 cycles the masked result and its mask are published, together with a
// single-cycle finish pulse.
// Note: rst_n is an active-high asynchronous reset despite its name.
module sub_nibble (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] m,
  input  logic [31:0] x,
  output logic        finish,
  output logic [31:0] x_out,
  output logic [31:0] m_out
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      r_state;
  logic        r_start_d;
  logic [2:0]  r_cnt;
  logic [31:0] r_x;
  logic [31:0] r_m;
  logic [31:0] r_res;
  logic        r_finish;
  logic [31:0] r_x_out;
  logic [31:0] r_m_out;

  logic        w_start_evt;
  logic [4:0]  w_bit_idx;
  logic [3:0]  w_nib_x;
  logic [3:0]  w_nib_m;
  logic [3:0]  w_nib_sub;
  logic [31:0] w_res_next;

  // 4-bit substitution table
  function automatic logic [3:0] sbox(input logic [3:0] d);
    logic [3:0] s;
    unique case (d)
      4'h0: s = 4'hC;
      4'h1: s = 4'h5;
      4'h2: s = 4'h6;
      4'h3: s = 4'hB;
      4'h4: s = 4'h9;
      4'h5: s = 4'h0;
      4'h6: s = 4'hA;
      4'h7: s = 4'hD;
      4'h8: s = 4'h3;
      4'h9: s = 4'hE;
      4'hA: s = 4'hF;
      4'hB: s = 4'h8;
      4'hC: s = 4'h4;
      4'hD: s = 4'h7;
      4'hE: s = 4'h1;
      default: s = 4'h2;
    endcase
    return s;
  endfunction

  // Rising edge of start, only honoured while idle
  assign w_start_evt = start & ~r_start_d & (r_state == StIdle);

  // Substitute the current nibble and merge it into the running result
  always_comb begin
    w_bit_idx  = {r_cnt, 2'b00};
    w_nib_x    = r_x[w_bit_idx +: 4];
    w_nib_m    = r_m[w_bit_idx +: 4];
    // Unmask, substitute, then re-apply the same mask nibble
    w_nib_sub  = sbox(w_nib_x ^ w_nib_m) ^ w_nib_m;
    w_res_next = r_res;
    w_res_next[w_bit_idx +: 4] = w_nib_sub;
  end

  // Control FSM with registered outputs; start_d tracks start in every state
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state   <= StIdle;
      r_start_d <= 1'b0;
      r_cnt     <= 3'd0;
      r_x       <= 32'd0;
      r_m       <= 32'd0;
      r_res     <= 32'd0;
      r_finish  <= 1'b0;
      r_x_out   <= 32'd0;
      r_m_out   <= 32'd0;
    end else begin
      r_start_d <= start;
      unique case (r_state)
        StIdle: begin
          if (w_start_evt) begin
            r_x     <= x;
            r_m     <= m;
            r_cnt   <= 3'd0;
            r_state <= StBusy;
          end
        end
        StBusy: begin
          r_res <= w_res_next;
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            // Last nibble: publish the completed word directly from the merge path
            r_x_out  <= w_res_next;
            r_m_out  <= r_m;
            r_finish <= 1'b1;
            r_state  <= StDone;
          end
        end
        StDone: begin
          r_finish <= 1'b0;
          r_state  <= StIdle;
        end
        default: begin
          r_finish <= 1'b0;
          r_state  <= StIdle;
        end
      endcase
    end
  end

  assign finish = r_finish;
  assign x_out  = r_x_out;
  assign m_out  = r_m_out;

endmodule

// File: tb/tb_sub_nibble.sv
// tb_sub_nibble: vector table plus multi-cycle corner sequences, scoreboard-checked.
module tb_sub_nibble;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] m;
  logic [31:0] x;
  logic        finish;
  logic [31:0] x_out;
  logic [31:0] m_out;

  sub_nibble u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .m      (m),
    .x      (x),
    .finish (finish),
    .x_out  (x_out),
    .m_out  (m_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] m;
    logic [31:0] exp_x;
    logic [31:0] exp_m;
  } vec_t;

  typedef struct {
    logic [31:0] exp_x;
    logic [31:0] exp_m;
    logic [31:0] exp_d;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_err;
  int   n_fin;
  logic prev_fin;

  function automatic logic [3:0] ref_s(input logic [3:0] d);
    logic [3:0] tbl [16];
    tbl = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
            4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    return tbl[d];
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] d);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*4 +: 4] = ref_s(d[i*4 +: 4]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] xv, input logic [31:0] mv);
    exp_t e;
    e.exp_d = ref_word(xv ^ mv);
    e.exp_m = mv;
    e.exp_x = e.exp_d ^ mv;
    sb_q.push_back(e);
  endtask

  // Advance one cycle and sample just after the edge; finish pulses are scored here
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (finish === 1'b1) begin
      n_fin++;
      if (prev_fin) begin
        n_cmp++;
        n_err++;
        $display("FAIL finish_width: got finish high 2 cycles required 1");
      end else if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_finish: got pulse required none (x_out=%h)", x_out);
      end else begin
        e = sb_q.pop_front();
        chk("x_out", x_out, e.exp_x);
        chk("m_out", m_out, e.exp_m);
        chk("unmasked", x_out ^ m_out, e.exp_d);
      end
    end
    prev_fin = (finish === 1'b1);
  endtask

  // Wait for the next finish pulse, bounded; returns cycles counted
  task automatic wait_done(output int lat);
    int f0;
    f0  = n_fin;
    lat = 0;
    while (n_fin == f0 && lat < 30) begin
      tick();
      lat++;
    end
    if (n_fin == f0) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: got no finish required one within 30 cycles");
    end
  endtask

  // Pulse start for one sampled cycle with fresh operands, then wait for completion
  task automatic run_op(input logic [31:0] xv, input logic [31:0] mv);
    int lat;
    x     = xv;
    m     = mv;
    start = 1'b1;
    push_exp(xv, mv);
    tick();
    start = 1'b0;
    wait_done(lat);
    chk("latency", lat, 8);
  endtask

  vec_t vecs [6];

  initial begin
    int          f0;
    int          lat;
    logic [31:0] hold_x;
    logic [31:0] hold_m;

    n_cmp    = 0;
    n_err    = 0;
    n_fin    = 0;
    prev_fin = 1'b0;
    rst_n    = 1'b1;
    start    = 1'b0;
    x        = '0;
    m        = '0;

    vecs[0] = '{32'h0000_0000, 32'h0000_0000, 32'hCCCC_CCCC, 32'h0000_0000};
    vecs[1] = '{32'h0123_4567, 32'h0000_0000, 32'hC56B_90AD, 32'h0000_0000};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h3333_3333, 32'hFFFF_FFFF};
    vecs[3] = '{32'h89AB_CDEF, 32'h0000_0000, 32'h3EF8_4712, 32'h0000_0000};
    vecs[4] = '{32'hA486_E0C2, 32'hA5A5_A5A5, 32'h60CE_3508, 32'hA5A5_A5A5};
    vecs[5] = '{32'h1357_9BDF, 32'h0F0F_F0F0, 32'h0000_0000, 32'h0F0F_F0F0};
    vecs[5].exp_x = ref_word(vecs[5].x ^ vecs[5].m) ^ vecs[5].m;

    // Reset state
    repeat (3) tick();
    chk("rst_finish", {31'd0, finish}, 32'd0);
    chk("rst_x_out", x_out, 32'd0);
    chk("rst_m_out", m_out, 32'd0);
    rst_n = 1'b0;
    repeat (2) tick();

    // Table-driven vectors: fixed expectations checked against the scoreboard model too
    foreach (vecs[i]) begin
      chk("table_model", ref_word(vecs[i].x ^ vecs[i].m) ^ vecs[i].m, vecs[i].exp_x);
      run_op(vecs[i].x, vecs[i].m);
      chk("table_x_out", x_out, vecs[i].exp_x);
      chk("table_m_out", m_out, vecs[i].exp_m);
      repeat (2) tick();
    end

    // Random operands
    for (int i = 0; i < 4; i++) begin
      run_op($urandom, $urandom);
      repeat (1 + (i % 3)) tick();
    end

    // Outputs hold between completions while inputs wander
    hold_x = x_out;
    hold_m = m_out;
    for (int i = 0; i < 6; i++) begin
      x = $urandom;
      m = $urandom;
      tick();
    end
    chk("hold_x_out", x_out, hold_x);
    chk("hold_m_out", m_out, hold_m);

    // Start held high for 40 cycles gives one operation; a fresh pulse gives another
    f0    = n_fin;
    x     = 32'h0123_4567;
    m     = 32'h0000_0000;
    start = 1'b1;
    push_exp(x, m);
    repeat (40) tick();
    chk("held_start_pulses", n_fin - f0, 1);
    start = 1'b0;
    tick();
    x     = 32'hDEAD_BEEF;
    m     = 32'h1234_5678;
    run_op(x, m);
    chk("second_pulse", n_fin - f0, 2);

    // Operand change and start pulse mid-operation are ignored
    repeat (2) tick();
    f0    = n_fin;
    x     = 32'h89AB_CDEF;
    m     = 32'h0000_0000;
    start = 1'b1;
    push_exp(x, m);
    tick();
    start = 1'b0;
    repeat (3) tick();
    x     = 32'h5555_5555;
    m     = 32'hAAAA_AAAA;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat);
    chk("mid_op_latency", lat, 4);
    repeat (12) tick();
    chk("mid_op_pulses", n_fin - f0, 1);
    chk("mid_op_x_out", x_out, 32'h3EF8_4712);

    // Reset mid-operation: outputs clear asynchronously, no pulse, later op is correct
    f0    = n_fin;
    x     = 32'hFFFF_FFFF;
    m     = 32'hFFFF_FFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    #2;
    rst_n = 1'b1;
    #1;
    chk("async_rst_x_out", x_out, 32'd0);
    chk("async_rst_m_out", m_out, 32'd0);
    chk("async_rst_finish", {31'd0, finish}, 32'd0);
    repeat (3) tick();
    rst_n = 1'b0;
    repeat (12) tick();
    chk("abort_no_pulse", n_fin - f0, 0);
    chk("abort_x_out", x_out, 32'd0);
    run_op(32'h0000_0000, 32'h0000_0000);

    // Start already high when reset releases counts as a start event
    rst_n = 1'b1;
    tick();
    x     = 32'h0123_4567;
    m     = 32'hFFFF_0000;
    start = 1'b1;
    push_exp(x, m);
    rst_n = 1'b0;
    tick();
    start = 1'b0;
    wait_done(lat);
    chk("rst_release_latency", lat, 8);
    repeat (4) tick();
    chk("queue_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
